// File: rtl/tx_p2s_fifo.sv
// rtl/tx_p2s_fifo.sv - FIFO-fed LSB-first serialiser with CRC5/CRC16 shift-enable windows
// Optional bit stuffing (stuffed 0 after six 1s) enabled by defining TX_BITSTUFF_EN.
module tx_p2s_fifo #(
  parameter int                DATA_W       = 8,
  parameter int                FIFO_DEPTH   = 4,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = DATA_W'(8'h80)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               tx_load,
  input  logic [DATA_W-1:0]                  tx_data,
  input  logic                               syn_gen_ld,
  input  logic                               tx_last_byte,
  input  logic                               crc_16,
  input  logic                               halt_tx_shift,
  output logic                               tdo,
  output logic                               tcs,
  output logic                               tx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               t_lastbit,
  output logic                               shift_tx_crc16,
  output logic                               shift_tx_crc5,
  output logic                               tx_underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              last_q, last_d;
  logic [4:0]        crc_cnt_q, crc_cnt_d;
  logic              crc16_q, crc16_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W:0]   head;
  logic              push, pop, fifo_empty;
  logic              stuff_now, bit_done, end_word;
`ifdef TX_BITSTUFF_EN
  logic [2:0]        ones_q, ones_d;
  logic              tail_q, tail_d;
`endif

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != LW'(FIFO_DEPTH));
  assign fifo_level = count_q;
  assign push       = tx_load && tx_ready;

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {tx_last_byte, syn_gen_ld ? SYNC_PATTERN : tx_data};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + LW'(push) - LW'(pop);
  end

  always_comb begin
    state_d        = state_q;
    sh_d           = sh_q;
    bit_cnt_d      = bit_cnt_q;
    last_d         = last_q;
    crc_cnt_d      = crc_cnt_q;
    crc16_d        = crc16_q;
    pop            = 1'b0;
    tdo            = 1'b1;
    tcs            = 1'b0;
    t_lastbit      = 1'b0;
    shift_tx_crc16 = 1'b0;
    shift_tx_crc5  = 1'b0;
    tx_underrun    = 1'b0;
    stuff_now      = 1'b0;
    bit_done       = 1'b0;
    end_word       = 1'b0;
`ifdef TX_BITSTUFF_EN
    ones_d    = ones_q;
    tail_d    = tail_q;
    stuff_now = (state_q == DATA) && (ones_q == 3'd6);
`endif
    case (state_q)
      IDLE: pop = !fifo_empty;
      DATA: begin
        tcs       = 1'b1;
        tdo       = stuff_now ? 1'b0 : sh_q[0];
        bit_done  = !stuff_now && (bit_cnt_q == LAST_BIT);
        t_lastbit = bit_done && last_q;
        end_word  = !halt_tx_shift && bit_done;
`ifdef TX_BITSTUFF_EN
        // A run of six ending on the final bit defers the word boundary past the stuffed 0.
        if (!halt_tx_shift) begin
          ones_d = tdo ? ones_q + 3'd1 : 3'd0;
          if (bit_done && (ones_q == 3'd5) && sh_q[0]) begin
            end_word = 1'b0;
            tail_d   = 1'b1;
          end
          if (stuff_now && tail_q) begin
            end_word = 1'b1;
            tail_d   = 1'b0;
          end
        end
`endif
        if (!halt_tx_shift && !stuff_now && !bit_done) begin
          sh_d      = sh_q >> 1;
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
        if (!halt_tx_shift && bit_done && last_q) crc16_d = crc_16;
        if (end_word) begin
          if (last_q) begin
            state_d   = CRC;
            crc_cnt_d = '0;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            tx_underrun = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      CRC: begin
        shift_tx_crc16 = crc16_q && !halt_tx_shift;
        shift_tx_crc5  = !crc16_q && !halt_tx_shift;
        if (!halt_tx_shift) begin
          if (crc_cnt_q == (crc16_q ? 5'd15 : 5'd4)) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_d = IDLE;
          end else begin
            crc_cnt_d = crc_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      sh_d      = head[DATA_W-1:0];
      last_d    = head[DATA_W];
      bit_cnt_d = '0;
      state_d   = DATA;
    end
`ifdef TX_BITSTUFF_EN
    if (state_q != DATA) begin
      ones_d = 3'd0;
      tail_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      crc_cnt_q <= '0;
      crc16_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef TX_BITSTUFF_EN
      ones_q    <= 3'd0;
      tail_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      crc_cnt_q <= crc_cnt_d;
      crc16_q   <= crc16_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
`ifdef TX_BITSTUFF_EN
      ones_q    <= ones_d;
      tail_q    <= tail_d;
`endif
    end
  end
endmodule

// File: tb/tb_tx_p2s_fifo.sv
// tb/tb_tx_p2s_fifo.sv - self-checking bench for tx_p2s_fifo
module tb_tx_p2s_fifo;
  localparam int W = 8;
  localparam int D = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tx_load = 1'b0, syn_gen_ld = 1'b0, tx_last_byte = 1'b0, crc_16 = 1'b0, halt_tx_shift = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic tdo, tcs, tx_ready, t_lastbit, shift_tx_crc16, shift_tx_crc5, tx_underrun;
  logic [2:0] fifo_level;

  tx_p2s_fifo dut (
    .clock(clock), .reset(reset), .tx_load(tx_load), .tx_data(tx_data),
    .syn_gen_ld(syn_gen_ld), .tx_last_byte(tx_last_byte), .crc_16(crc_16),
    .halt_tx_shift(halt_tx_shift), .tdo(tdo), .tcs(tcs), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .t_lastbit(t_lastbit), .shift_tx_crc16(shift_tx_crc16),
    .shift_tx_crc5(shift_tx_crc5), .tx_underrun(tx_underrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {tdo, tcs, tx_ready, fifo_level, t_lastbit, shift_tx_crc16, shift_tx_crc5, tx_underrun};
  endfunction

  // Reference model: a queue of entries plus "what is on the wire now".
  logic [W:0] mq[$];
  int m_phase = 0;
  logic [W-1:0] m_word = '0;
  logic m_last = 1'b0;
  int m_bit = 0;
  int m_crc_left = 0;
  logic m_c16 = 1'b0;

  task automatic model_check();
`ifndef TX_BITSTUFF_EN
    logic e_tdo, e_tcs, e_lb, e_c16, e_c5, e_un;
    e_tdo = 1'b1; e_tcs = 1'b0; e_lb = 1'b0; e_c16 = 1'b0; e_c5 = 1'b0; e_un = 1'b0;
    if (m_phase == 1) begin
      e_tdo = m_word[m_bit];
      e_tcs = 1'b1;
      e_lb  = (m_bit == W-1) && m_last;
      e_un  = (m_bit == W-1) && !m_last && (mq.size() == 0) && !halt_tx_shift;
    end else if (m_phase == 2) begin
      e_c16 = m_c16 && !halt_tx_shift;
      e_c5  = !m_c16 && !halt_tx_shift;
    end
    check("model", outs(), {e_tdo, e_tcs, mq.size() != D, 3'(mq.size()), e_lb, e_c16, e_c5, e_un});
`endif
  endtask

  task automatic model_edge();
    logic [W:0] ent;
    bit take;
    int sz;
    take = 0;
    sz = mq.size();
    if (m_phase == 0) begin
      take = (sz != 0);
    end else if (m_phase == 1 && !halt_tx_shift) begin
      if (m_bit < W-1) m_bit++;
      else if (m_last) begin m_phase = 2; m_c16 = crc_16; m_crc_left = crc_16 ? 16 : 5; end
      else if (sz != 0) take = 1;
      else m_phase = 0;
    end else if (m_phase == 2 && !halt_tx_shift) begin
      m_crc_left--;
      if (m_crc_left == 0) begin
        if (sz != 0) take = 1;
        else m_phase = 0;
      end
    end
    if (take) begin
      ent = mq.pop_front();
      m_word = ent[W-1:0]; m_last = ent[W]; m_bit = 0; m_phase = 1;
    end
    if (tx_load && sz != D) mq.push_back({tx_last_byte, syn_gen_ld ? 8'h80 : tx_data});
  endtask

  task automatic tick(input logic ld, input logic [W-1:0] d, input logic sy, input logic la,
                      input logic c16, input logic h);
    @(negedge clock);
    tx_load = ld; tx_data = d; syn_gen_ld = sy; tx_last_byte = la; crc_16 = c16; halt_tx_shift = h;
    #1;
    model_check();
    model_edge();
  endtask

  task automatic do_reset(input string name);
    #2;
    reset = 1'b0;
    tx_load = 1'b0; syn_gen_ld = 1'b0; tx_last_byte = 1'b0; halt_tx_shift = 1'b0;
    #1;
    check(name, outs(), 10'b1_0_1_000_0000);
    mq.delete();
    m_phase = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] d;
    logic       la;
    logic [9:0] exp;
  } vec_t;

  function automatic vec_t mkv(input logic ld, input logic [7:0] d, input logic la, input logic [9:0] exp);
    vec_t v;
    v.ld = ld; v.d = d; v.la = la; v.exp = exp;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [7:0] a5;
    logic [7:0] got;
    int tcs_cnt, rises, j, und_cnt, und_at;
    logic prev_tcs, held;

    // A5 tagged last with CRC5: write, idle pop cycle, 8 bits, 5 CRC cycles, idle.
    a5 = 8'hA5;
    tbl.push_back(mkv(1'b1, 8'hA5, 1'b1, 10'b1_0_1_000_0000));
    tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 10'b1_0_1_001_0000));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mkv(1'b0, 8'h00, 1'b0, {a5[i], 1'b1, 1'b1, 3'd0, (i == 7), 3'b000}));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 10'b1_0_1_000_0010));
    tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 10'b1_0_1_000_0000));

    do_reset("reset_initial");

    foreach (tbl[i]) begin
      tick(tbl[i].ld, tbl[i].d, 1'b0, tbl[i].la, 1'b0, 1'b0);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Fill the FIFO with tx_load held; the sixth attempt must bounce.
    tcs_cnt = 0; rises = 0; prev_tcs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 8'(i + 1), 1'b0, (i >= 4), 1'b0, 1'b0);
      if (i == 5) begin
        check("full_ready", tx_ready, 1'b0);
        check("full_level", fifo_level, 3'd4);
      end
      if (tcs && !prev_tcs) rises++;
      if (tcs) tcs_cnt++;
      prev_tcs = tcs;
    end
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 0) check("rejected_level", fifo_level, 3'd4);
      if (tcs && !prev_tcs) rises++;
      if (tcs) tcs_cnt++;
      prev_tcs = tcs;
    end
    check("burst_tcs_cycles", tcs_cnt, 40);
    check("burst_tcs_contiguous", rises, 1);

    // Sync request replaces tx_data with the sync pattern.
    got = '0; j = 0;
    tick(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      if (tcs && j < 8) begin got[j] = tdo; j++; end
    end
    check("sync_pattern", got, 8'h80);

    // Halt for three cycles while bit 3 is on the wire.
    got = '0; j = 0; tcs_cnt = 0; held = 1'b1;
    tick(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, (tcs_cnt >= 3 && tcs_cnt < 6));
      if (tcs) begin
        if (halt_tx_shift && tdo !== 1'b0) held = 1'b0;
        if (!halt_tx_shift && j < 8) begin got[j] = tdo; j++; end
        tcs_cnt++;
      end
    end
    check("halt_frozen_bit", held, 1'b1);
    check("halt_byte", got, 8'hA5);
    check("halt_tcs_cycles", tcs_cnt, 11);

    // Untagged word with nothing behind it underruns after its final bit.
    und_cnt = 0; und_at = -1; tcs_cnt = 0;
    tick(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      if (tx_underrun) begin und_cnt++; und_at = tcs_cnt; end
      if (tcs) tcs_cnt++;
    end
    check("underrun_pulses", und_cnt, 1);
    check("underrun_bit", und_at, 7);
    check("underrun_idle", tcs, 1'b0);

    // Reset in the middle of a byte discards it.
    tick(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_busy", tcs, 1'b1);
    do_reset("reset_mid_byte");
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_idle", outs(), 10'b1_0_1_000_0000);

`ifndef TX_BITSTUFF_EN
    for (int i = 0; i < 3000; i++)
      tick(($urandom % 3) == 0, 8'($urandom), ($urandom % 8) == 0, ($urandom % 4) == 0,
           1'($urandom), ($urandom % 10) == 0);
`else
    // FF then 00: stuffed 0 after the sixth 1, then the remaining two 1s, then CRC16.
    begin
      logic [16:0] seq;
      int c16_cnt;
      seq = '0; j = 0; c16_cnt = 0;
      tick(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 50; i++) begin
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        if (tcs) begin seq = {seq[15:0], tdo}; j++; end
        if (shift_tx_crc16) c16_cnt++;
      end
      check("stuff_bits", seq, 17'b11111101100000000);
      check("stuff_tcs_cycles", j, 17);
      check("stuff_crc16_cycles", c16_cnt, 16);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
